// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: default instruction width, NOP encoding and
// the program-load FSM state encoding.
package mips_pkg;

  localparam int unsigned MIPS_DATA_W = 32;
  localparam logic [MIPS_DATA_W-1:0] MIPS_NOP_WORD = '0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } load_state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM with one write port and a registered read port,
// written in a form that maps onto block RAM.
module imem_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: contents and read register survive reset so this stays BRAM-inferable.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/prog_instr_memory.sv
// Instruction memory for the pipelined MIPS core: 1-cycle registered fetch port plus a
// valid/ready streaming load port with auto-incrementing write pointer.
module prog_instr_memory
  import mips_pkg::*;
#(
  parameter int unsigned       DATA_W    = MIPS_DATA_W,
  parameter int unsigned       DEPTH     = 64,
  parameter int unsigned       ADDR_W    = 32,
  parameter bit                BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(MIPS_NOP_WORD)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_en,
  input  logic [ADDR_W-1:0]        pc,
  output logic [DATA_W-1:0]        instr,
  output logic                     fetch_fault,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic                     load_last,
  input  logic [DATA_W-1:0]        load_data,
  output logic                     load_ready,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     load_overrun,
  output logic [$clog2(DEPTH):0]   prog_words
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = IdxW + 1;

  load_state_e       state_q;
  logic [CntW-1:0]   wptr_q;
  logic              overrun_q;
  logic              fault_q;
  logic              nop_q;

  logic [ADDR_W-1:0] idx_full;
  logic              misaligned;
  logic              in_range;
  logic              busy;
  logic              full;
  logic              ready;
  logic              ram_we;
  logic              ram_re;
  logic [IdxW-1:0]   ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  // Range check uses the full-width index so high PC bits cannot alias into the array.
  assign idx_full   = BYTE_ADDR ? (pc >> 2) : pc;
  assign misaligned = BYTE_ADDR && (pc[1:0] != 2'b00);
  assign in_range   = (idx_full < ADDR_W'(DEPTH)) && !misaligned;

  assign busy   = (state_q == StLoad);
  assign full   = (wptr_q == CntW'(DEPTH));
  assign ready  = busy && !full;
  assign ram_we = ready && load_valid && !load_start;
  assign ram_re = !busy && fetch_en && in_range;
  assign ram_addr = busy ? wptr_q[IdxW-1:0] : idx_full[IdxW-1:0];

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IdxW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      wptr_q    <= '0;
      overrun_q <= 1'b0;
      fault_q   <= 1'b0;
      nop_q     <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (load_start) begin
            state_q   <= StLoad;
            wptr_q    <= '0;
            overrun_q <= 1'b0;
          end
        end
        StLoad: begin
          if (load_start) begin
            wptr_q <= '0;
          end else if (load_valid) begin
            if (!full) begin
              wptr_q <= wptr_q + CntW'(1);
              if (load_last) begin
                state_q <= StDone;
              end
            end else begin
              overrun_q <= 1'b1;
              state_q   <= StDone;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // nop_q selects NOP_WORD over the RAM read register; both hold when fetch_en=0.
      if (busy) begin
        nop_q   <= 1'b1;
        fault_q <= 1'b0;
      end else if (fetch_en) begin
        nop_q   <= !in_range;
        fault_q <= !in_range;
      end
    end
  end

  assign instr        = (busy || nop_q) ? NOP_WORD : ram_rdata;
  assign fetch_fault  = fault_q && !busy;
  assign load_ready   = ready;
  assign load_busy    = busy;
  assign load_done    = (state_q == StDone);
  assign load_overrun = overrun_q;
  // Write pointer and stored-word count move together, so one register serves both.
  assign prog_words   = wptr_q;

endmodule

// File: tb/tb_prog_instr_memory.sv
// Directed bench: instance a (DEPTH=64, byte PC) and instance b (DEPTH=4, word PC).
module tb_prog_instr_memory;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance a: default configuration
  logic        a_fetch_en = 0, a_load_start = 0, a_load_valid = 0, a_load_last = 0;
  logic [31:0] a_pc = 0, a_load_data = 0;
  logic [31:0] a_instr;
  logic        a_fault, a_ready, a_busy, a_done, a_overrun;
  logic [6:0]  a_words;

  // Instance b: DEPTH=4, word-indexed PC
  logic        b_fetch_en = 0, b_load_start = 0, b_load_valid = 0, b_load_last = 0;
  logic [31:0] b_pc = 0, b_load_data = 0;
  logic [31:0] b_instr;
  logic        b_fault, b_ready, b_busy, b_done, b_overrun;
  logic [2:0]  b_words;

  prog_instr_memory u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (a_fetch_en),
    .pc           (a_pc),
    .instr        (a_instr),
    .fetch_fault  (a_fault),
    .load_start   (a_load_start),
    .load_valid   (a_load_valid),
    .load_last    (a_load_last),
    .load_data    (a_load_data),
    .load_ready   (a_ready),
    .load_busy    (a_busy),
    .load_done    (a_done),
    .load_overrun (a_overrun),
    .prog_words   (a_words)
  );

  prog_instr_memory #(
    .DEPTH     (4),
    .BYTE_ADDR (1'b0)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (b_fetch_en),
    .pc           (b_pc),
    .instr        (b_instr),
    .fetch_fault  (b_fault),
    .load_start   (b_load_start),
    .load_valid   (b_load_valid),
    .load_last    (b_load_last),
    .load_data    (b_load_data),
    .load_ready   (b_ready),
    .load_busy    (b_busy),
    .load_done    (b_done),
    .load_overrun (b_overrun),
    .prog_words   (b_words)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  localparam logic [31:0] W0 = 32'h0022_1820;
  localparam logic [31:0] W1 = 32'h0022_2022;
  localparam logic [31:0] W2 = 32'h0022_2824;

  initial begin
    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", a_instr, 32'h0);
    chk("rst_fault", {31'b0, a_fault}, 32'h0);
    chk("rst_ready", {31'b0, a_ready}, 32'h0);
    chk("rst_busy", {31'b0, a_busy}, 32'h0);
    chk("rst_done", {31'b0, a_done}, 32'h0);
    chk("rst_overrun", {31'b0, a_overrun}, 32'h0);
    chk("rst_words", {25'b0, a_words}, 32'h0);
    rst = 1'b1;
    tick();

    // Three-word program load
    a_load_start = 1;
    tick();
    a_load_start = 0;
    chk("load_busy", {31'b0, a_busy}, 32'h1);
    chk("load_ready", {31'b0, a_ready}, 32'h1);
    a_load_valid = 1; a_load_data = W0;
    tick();
    a_load_data = W1;
    tick();
    a_load_data = W2; a_load_last = 1;
    tick();
    chk("load_done_pulse", {31'b0, a_done}, 32'h1);
    chk("load_busy_off", {31'b0, a_busy}, 32'h0);
    chk("load_words3", {25'b0, a_words}, 32'd3);
    a_load_valid = 0; a_load_last = 0;
    tick();
    chk("load_done_gone", {31'b0, a_done}, 32'h0);
    chk("load_words_hold", {25'b0, a_words}, 32'd3);

    // Fetch back pc=0,4,8
    a_fetch_en = 1; a_pc = 0;
    tick();
    chk("fetch_pc0", a_instr, W0);
    a_pc = 4;
    tick();
    chk("fetch_pc4", a_instr, W1);
    a_pc = 8;
    tick();
    chk("fetch_pc8", a_instr, W2);
    chk("fetch_nofault", {31'b0, a_fault}, 32'h0);

    // Stall holds instr
    a_pc = 4;
    tick();
    a_fetch_en = 0; a_pc = 8;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", a_instr, W1);
    end

    // Misaligned and out-of-range fetches
    a_fetch_en = 1; a_pc = 6;
    tick();
    chk("misalign_fault", {31'b0, a_fault}, 32'h1);
    chk("misalign_instr", a_instr, 32'h0);
    a_pc = 256;
    tick();
    chk("range_fault", {31'b0, a_fault}, 32'h1);
    chk("range_instr", a_instr, 32'h0);
    a_pc = 0;
    tick();
    chk("refetch_pc0", a_instr, W0);
    chk("refetch_nofault", {31'b0, a_fault}, 32'h0);

    // Load with valid gaps and a restart after two words; fetch_en stays high
    a_load_start = 1;
    tick();
    a_load_start = 0;
    chk("busy_instr_nop", a_instr, 32'h0);
    a_load_valid = 1; a_load_data = 32'hAAAA_0001;
    tick();
    a_load_valid = 0;
    tick();
    chk("gap_no_accept", {25'b0, a_words}, 32'd1);
    a_load_valid = 1; a_load_data = 32'hAAAA_0002;
    tick();
    chk("two_words", {25'b0, a_words}, 32'd2);
    chk("busy_instr_nop2", a_instr, 32'h0);
    a_load_start = 1; a_load_data = 32'hDEAD_0000;
    tick();
    a_load_start = 0;
    chk("restart_words", {25'b0, a_words}, 32'd0);
    chk("restart_busy", {31'b0, a_busy}, 32'h1);
    a_load_data = 32'h1111_0000;
    tick();
    a_load_valid = 0;
    tick();
    chk("busy_instr_nop3", a_instr, 32'h0);
    a_load_valid = 1; a_load_data = 32'h2222_0000; a_load_last = 1;
    tick();
    chk("restart_done", {31'b0, a_done}, 32'h1);
    chk("restart_words2", {25'b0, a_words}, 32'd2);
    a_load_valid = 0; a_load_last = 0;
    tick();
    chk("restart_fetch0", a_instr, 32'h1111_0000);
    a_pc = 4;
    tick();
    chk("restart_fetch4", a_instr, 32'h2222_0000);
    a_pc = 8;
    tick();
    chk("old_word_kept", a_instr, W2);

    // Overrun on the DEPTH=4 instance
    b_load_start = 1;
    tick();
    b_load_start = 0;
    b_load_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b_load_data = 32'hB0 + 32'(i);
      tick();
    end
    chk("b_full_ready", {31'b0, b_ready}, 32'h0);
    chk("b_full_busy", {31'b0, b_busy}, 32'h1);
    chk("b_no_overrun_yet", {31'b0, b_overrun}, 32'h0);
    b_load_data = 32'hB4;
    tick();
    chk("b_overrun", {31'b0, b_overrun}, 32'h1);
    chk("b_done", {31'b0, b_done}, 32'h1);
    chk("b_words4", {29'b0, b_words}, 32'd4);
    b_load_valid = 0;
    tick();
    chk("b_overrun_sticky", {31'b0, b_overrun}, 32'h1);
    chk("b_done_gone", {31'b0, b_done}, 32'h0);

    // Word-indexed boundary fetches
    b_fetch_en = 1; b_pc = 4;
    tick();
    chk("b_pc_depth_fault", {31'b0, b_fault}, 32'h1);
    chk("b_pc_depth_instr", b_instr, 32'h0);
    b_pc = 3;
    tick();
    chk("b_pc_last", b_instr, 32'hB3);
    chk("b_pc_last_fault", {31'b0, b_fault}, 32'h0);
    b_pc = 0;
    tick();
    chk("b_pc0", b_instr, 32'hB0);

    // Asynchronous reset in the middle of a load
    a_load_start = 1;
    tick();
    a_load_start = 0;
    a_load_valid = 1; a_load_data = 32'h3333_0000;
    tick();
    a_load_valid = 0;
    chk("pre_rst_ready", {31'b0, a_ready}, 32'h1);
    chk("pre_rst_words", {25'b0, a_words}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_instr", a_instr, 32'h0);
    chk("async_ready", {31'b0, a_ready}, 32'h0);
    chk("async_busy", {31'b0, a_busy}, 32'h0);
    chk("async_words", {25'b0, a_words}, 32'h0);
    chk("async_b_instr", b_instr, 32'h0);
    chk("async_b_overrun", {31'b0, b_overrun}, 32'h0);
    chk("async_b_words", {29'b0, b_words}, 32'h0);
    #2;
    rst = 1'b1;
    a_fetch_en = 1; a_pc = 0;
    tick();
    chk("post_rst_kept", a_instr, 32'h3333_0000);
    chk("post_rst_busy", {31'b0, a_busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
